// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler slice.
// Optional MD_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package md_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } md_state_t;

  // Ops that occupy the unit for MULT_CYCLES.
  function automatic logic is_mul_op(input logic [MD_OP_W-1:0] op);
`ifdef MD_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// E-stage <-> MD unit signal bundle; master is the pipeline, slave the scheduler.
interface md_scheduler_if;
  import md_pkg::*;

  logic                start;
  logic [MD_OP_W-1:0]  op;
  logic [31:0]         a;
  logic [31:0]         b;
  logic                flush;
  logic                md_in_d;
  logic                busy;
  logic                stall;
  logic [31:0]         hi;
  logic [31:0]         lo;

  modport master (output start, op, a, b, flush, md_in_d,
                  input  busy, stall, hi, lo);
  modport slave  (input  start, op, a, b, flush, md_in_d,
                  output busy, stall, hi, lo);
endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit HI/LO result for an MD op from operands and current HI/LO.
// Optional MD_MADD_EN adds the multiply-accumulate/subtract paths.
module md_arith
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic [31:0]        hi,
  input  logic [31:0]        lo,
  output logic [31:0]        pending_hi,
  output logic [31:0]        pending_lo
);

  logic [63:0] prod_s, prod_u, res;
  logic [31:0] mag_a, mag_b, sdiv, udiv, sq_mag, sr_mag, sq, sr;
  logic        b_zero;

  assign prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign b_zero = (b == '0);
  assign mag_a  = a[31] ? (~a + 32'd1) : a;
  assign mag_b  = b[31] ? (~b + 32'd1) : b;
  assign sdiv   = b_zero ? 32'd1 : mag_b;
  assign udiv   = b_zero ? 32'd1 : b;
  assign sq_mag = mag_a / sdiv;
  assign sr_mag = mag_a % sdiv;
  assign sq     = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr     = a[31] ? (~sr_mag + 32'd1) : sr_mag;

  always_comb begin
    res = {hi, lo};
    case (md_op_t'(op))
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   if (!b_zero) res = {sr, sq};
      MD_DIVU:  if (!b_zero) res = {a % udiv, a / udiv};
`ifdef MD_MADD_EN
      MD_MADD:  res = {hi, lo} + prod_s;
      MD_MADDU: res = {hi, lo} + prod_u;
      MD_MSUB:  res = {hi, lo} - prod_s;
      MD_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res = {hi, lo};
    endcase
  end

  assign pending_hi = res[63:32];
  assign pending_lo = res[31:0];

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: issue FSM, latency counter, HI/LO registers, D-stage stall.
// Optional MD_MADD_EN enables accumulate ops (handled in md_pkg / md_arith).
module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  md_scheduler_if.slave    bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q, pend_hi, pend_lo, res_hi, res_lo;
  logic             is_mul, is_div, eff_start;

  md_arith u_arith (
    .op         (bus.op),
    .a          (bus.a),
    .b          (bus.b),
    .hi         (hi_q),
    .lo         (lo_q),
    .pending_hi (res_hi),
    .pending_lo (res_lo)
  );

  assign is_mul    = is_mul_op(bus.op);
  assign is_div    = is_div_op(bus.op);
  assign eff_start = bus.start & ~bus.flush & (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eff_start) begin
            if (is_mul) begin
              state   <= ST_MUL;
              cnt     <= CNT_W'(MULT_CYCLES);
              pend_hi <= res_hi;
              pend_lo <= res_lo;
            end else if (is_div) begin
              state   <= ST_DIV;
              cnt     <= CNT_W'(DIV_CYCLES);
              pend_hi <= res_hi;
              pend_lo <= res_lo;
            end else if (bus.op == MD_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.op == MD_MTLO) begin
              lo_q <= bus.a;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi_q  <= pend_hi;
            lo_q  <= pend_lo;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall is combinational so the waiting D instruction also holds in the issue cycle.
  assign bus.busy  = (state != ST_IDLE);
  assign bus.stall = bus.md_in_d &
                     ((state != ST_IDLE) | (bus.start & ~bus.flush & (is_mul | is_div)));
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_scheduler;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic st_issue;
  int   nbusy, nstall;

  always #5 clk = ~clk;

  md_scheduler_if bus ();

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // The hazard unit must never present an op while the unit is busy.
  always @(negedge clk)
    if (!reset) assert (!(bus.start && bus.busy)) else $error("start while busy");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op; returns issue-cycle stall, busy length and stall cycles while busy.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic flush_busy,
                        output logic s_issue, output int nb, output int ns);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    #1 s_issue = bus.stall;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
    bus.flush = flush_busy;
    nb = 0; ns = 0;
    while (bus.busy && nb < 40) begin
      ns += int'(bus.stall);
      @(posedge clk); #1;
      nb++;
    end
    bus.flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = MD_NONE; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.md_in_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  bus.busy,  1'b0);
    check("rst_hi",    bus.hi,    32'h0);
    check("rst_lo",    bus.lo,    32'h0);
    check("rst_stall", bus.stall, 1'b0);
    @(negedge clk) reset = 1'b0;

    // MULT -2 * 3 with a dependent D instruction
    bus.md_in_d = 1'b1;
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, st_issue, nbusy, nstall);
    check("mult_stall_issue", st_issue, 1'b1);
    check("mult_busy_len",    nbusy, 5);
    check("mult_stall_len",   nstall, 5);
    check("mult_stall_after", bus.stall, 1'b0);
    check("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // MULTU same operands, no D dependency
    bus.md_in_d = 1'b0;
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, st_issue, nbusy, nstall);
    check("multu_stall_issue", st_issue, 1'b0);
    check("multu_busy_len",    nbusy, 5);
    check("multu_stall_len",   nstall, 0);
    check("multu_hilo", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, st_issue, nbusy, nstall);
    check("div_busy_len", nbusy, 10);
    check("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(MD_DIVU, 32'd7, 32'd0, 1'b0, st_issue, nbusy, nstall);
    check("divu0_busy_len", nbusy, 10);
    check("divu0_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st_issue, nbusy, nstall);
    check("div_ovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, st_issue, nbusy, nstall);
    check("divu_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

    // Flushed start does nothing, stall suppressed
    bus.md_in_d = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_MULT; bus.a = 32'd9; bus.b = 32'd9;
    #1 check("flush_stall", bus.stall, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = MD_NONE;
    check("flush_busy", bus.busy, 1'b0);
    repeat (6) @(posedge clk);
    #1 check("flush_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);
    bus.md_in_d = 1'b0;

    // MTLO / MTHI: single-cycle, no busy
    run_op(MD_MTLO, 32'h0000_1234, 32'd0, 1'b0, st_issue, nbusy, nstall);
    check("mtlo_busy", nbusy, 0);
    check("mtlo_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_1234);
    run_op(MD_MTHI, 32'h0000_CAFE, 32'd0, 1'b0, st_issue, nbusy, nstall);
    check("mthi_hilo", {bus.hi, bus.lo}, 64'h0000_CAFE_0000_1234);

    // Undefined op code with start: no change
    run_op(4'd15, 32'h1111_1111, 32'h2222_2222, 1'b0, st_issue, nbusy, nstall);
    check("undef_busy", nbusy, 0);
    check("undef_hilo", {bus.hi, bus.lo}, 64'h0000_CAFE_0000_1234);

    // Flush while busy must not cancel the running op
    run_op(MD_MULTU, 32'd5, 32'd7, 1'b1, st_issue, nbusy, nstall);
    check("flushbusy_len",  nbusy, 5);
    check("flushbusy_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0023);

    // Reset in the middle of a DIV
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'd100; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
    @(negedge clk) reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("midrst_discard", {bus.hi, bus.lo}, 64'h0);
    run_op(MD_MULT, 32'd6, 32'd7, 1'b0, st_issue, nbusy, nstall);
    check("post_rst_len",  nbusy, 5);
    check("post_rst_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);

`ifdef MD_MADD_EN
    run_op(MD_MTHI, 32'h0, 32'd0, 1'b0, st_issue, nbusy, nstall);
    run_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, st_issue, nbusy, nstall);
    run_op(MD_MADDU, 32'd1, 32'd1, 1'b0, st_issue, nbusy, nstall);
    check("maddu_len",  nbusy, 5);
    check("maddu_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    run_op(MD_MSUB, 32'd2, 32'hFFFF_FFFF, 1'b0, st_issue, nbusy, nstall);
    check("msub_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0002);
`else
    bus.md_in_d = 1'b1;
    run_op(MD_MADDU, 32'd1, 32'd1, 1'b0, st_issue, nbusy, nstall);
    check("madd_off_stall", st_issue, 1'b0);
    check("madd_off_busy",  nbusy, 0);
    check("madd_off_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);
    bus.md_in_d = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
